zjh_scan_ctrl: RTL and testbench
================================

ZJH_SCAN_CTRL -- requirements
Module: zjh_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: Clock cycles per digit scan slot, legal range 2..65535.
REQ-002 Parameter BLANK, default 2: Clock cycles of forced blanking at the start of each slot, legal range 1..DIV-1.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Aclr  input  1  reset, synchronous and active-high.
REQ-005 Din  input  16  four BCD digits; digit0 (rightmost) in [3:0], digit3 in [15:12].
REQ-006 Din_valid  input  1  Din is offered this cycle.
REQ-007 Din_ready  output  1  shadow register is empty and accepts Din.
REQ-008 Lzb  input  1  leading-zero blanking enable; sampled every cycle.
REQ-009 Sel  output  2  active digit index; drives the 74HC138 A[1:0] inputs.
REQ-010 Bcd  output  4  BCD code of the active digit; drives the 74HC4511 D inputs.
REQ-011 BI_n  output  1  active-low blank; drives the 74HC4511 BI input.
REQ-012 Frame  output  1  one-cycle pulse when Sel wraps from 3 to 0.

Function
REQ-013 Prescaler counts 0..DIV-1 and wraps. At count DIV-1 a slot boundary occurs: Sel increments on that edge, 3 wraps to 0.
REQ-014 At each slot boundary the blank counter loads BLANK. It decrements to 0 one per cycle. While it is nonzero, BI_n SHALL be 0.
REQ-015 Handshake: a transfer occurs when Din_valid=1 and Din_ready=1. The shadow register captures Din. Din_ready goes 0 on the next cycle.
REQ-016 At the slot boundary where Sel goes 3->0, a full shadow is copied into the display register. The shadow is then empty, so Din_ready=1 on the following cycle. An empty shadow leaves the display register unchanged.
REQ-017 There is no bypass path. If Din is accepted in the same cycle as a 3->0 boundary, it is displayed from the next 3->0 boundary.
REQ-018 Display data changes only at frame boundaries. No frame ever shows digits from two different loads.
REQ-019 Bcd and Sel are registered. Bcd equals the display-register digit indexed by Sel, and both update on the same edge.
REQ-020 After blanking ends, BI_n=1 unless one of these applies: (a) the active digit is greater than 9, giving BI_n=0; or (b) Lzb=1, Sel is not 0, and the active digit and all higher-index digits are 0, giving BI_n=0.
REQ-021 Digit 0 is never blanked by leading-zero blanking.
REQ-022 Frame=1 for exactly the cycle following the 3->0 boundary edge, i.e. the first cycle with Sel=0.
REQ-023 Din_valid held high with Din_ready=0 has no effect and Din is not captured. Din may change freely while Din_ready=0.
REQ-024 Lzb changes take effect on the next registered BI_n update.

Reset
REQ-025 When Aclr=1 at a rising Clock edge, the following SHALL hold after that edge: prescaler=0; Sel=0; display register=0x0000; shadow empty; Din_ready=1; Bcd=0; Frame=0; blank counter=BLANK; BI_n=0.
REQ-026 Aclr overrides every concurrent event, including a handshake and a boundary in the same cycle. A pending shadow load is discarded.
REQ-027 After Aclr falls, the first slot boundary occurs DIV cycles later.

Verification (DIV=4, BLANK=1 unless noted)
REQ-028 Reset, then idle 16 cycles -> Sel sequence 0,1,2,3,0 with 4 cycles per step. BI_n is 0 in the first cycle of each slot. Bcd=0 throughout. Frame pulses once, at cycle 16.
REQ-029 Load Din=0x1234 mid-frame -> Din_ready drops for one frame. From the next Sel=0 onward, Bcd is 4,3,2,1 for Sel 0..3.
REQ-030 Load 0x0012 with Lzb=1 -> BI_n=0 outside blanking for Sel 2 and 3, and BI_n=1 for Sel 0 and 1. Load 0x0000 -> only Sel 0 is unblanked, showing 0.
REQ-031 Load 0x1A34 -> BI_n=0 throughout the Sel=2 slot, and the other digits display normally.
REQ-032 Din_valid=1 coincident with the 3->0 boundary while the shadow is empty -> Din is captured but not shown until the following frame. A second Din_valid before that frame is not accepted.
REQ-033 Assert Aclr mid-frame while the shadow is full -> the next cycle shows Sel=0, Bcd=0, BI_n=0 and Din_ready=1. The discarded data never appears.

Source files
------------

// File: rtl/zjh_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner for a 74HC138 + 74HC4511 pair.
// Accepts new digits through a one-word shadow register and applies them only at frame boundaries.
module zjh_scan_ctrl #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic        Clock,
    input  logic        Aclr,
    input  logic [15:0] Din,
    input  logic        Din_valid,
    output logic        Din_ready,
    input  logic        Lzb,
    output logic [1:0]  Sel,
    output logic [3:0]  Bcd,
    output logic        BI_n,
    output logic        Frame
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(BLANK + 1);

    logic [CW-1:0] presc_q, presc_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          full_q, full_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          bi_n_q, bi_n_d;
    logic          frame_q, frame_d;

    logic slot_end;
    logic frame_end;
    logic xfer;
    logic upper_zero;

    always_comb begin
        slot_end  = (presc_q == CW'(DIV - 1));
        frame_end = slot_end && (sel_q == 2'd3);
        xfer      = Din_valid && !full_q;

        presc_d = slot_end ? '0 : presc_q + 1'b1;
        sel_d   = slot_end ? sel_q + 2'd1 : sel_q;
        if (slot_end) begin
            blank_d = BW'(BLANK);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end else begin
            blank_d = blank_q;
        end

        // No bypass: a word captured on the frame edge waits for the next frame edge.
        disp_d   = (frame_end && full_q) ? shadow_q : disp_q;
        shadow_d = xfer ? Din : shadow_q;
        full_d   = full_q;
        if (frame_end && full_q) begin
            full_d = 1'b0;
        end
        if (xfer) begin
            full_d = 1'b1;
        end

        // Outputs are computed from next-state values so Sel, Bcd and BI_n move together.
        bcd_d = disp_d[{sel_d, 2'b00} +: 4];
        unique case (sel_d)
            2'd0:    upper_zero = 1'b0;
            2'd1:    upper_zero = (disp_d[15:4] == 12'h000);
            2'd2:    upper_zero = (disp_d[15:8] == 8'h00);
            default: upper_zero = (disp_d[15:12] == 4'h0);
        endcase
        bi_n_d  = (blank_d == '0) && (bcd_d <= 4'd9) && !(Lzb && upper_zero);
        frame_d = frame_end;
    end

    always_ff @(posedge Clock) begin
        if (Aclr) begin
            presc_q  <= '0;
            blank_q  <= BW'(BLANK);
            sel_q    <= 2'd0;
            disp_q   <= 16'h0000;
            shadow_q <= 16'h0000;
            full_q   <= 1'b0;
            bcd_q    <= 4'h0;
            bi_n_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            blank_q  <= blank_d;
            sel_q    <= sel_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            bcd_q    <= bcd_d;
            bi_n_q   <= bi_n_d;
            frame_q  <= frame_d;
        end
    end

    assign Din_ready = !full_q;
    assign Sel       = sel_q;
    assign Bcd       = bcd_q;
    assign BI_n      = bi_n_q;
    assign Frame     = frame_q;

endmodule

// File: tb/tb_zjh_scan_ctrl.sv
// Directed bench for zjh_scan_ctrl at DIV=4, BLANK=1 (16-cycle frames).
// Tracks frame position in the bench and checks every cycle of selected frames.
module tb_zjh_scan_ctrl;

    logic        Clock = 1'b0;
    logic        Aclr = 1'b1;
    logic [15:0] Din = 16'h0000;
    logic        Din_valid = 1'b0;
    logic        Lzb = 1'b0;
    logic        Din_ready;
    logic [1:0]  Sel;
    logic [3:0]  Bcd;
    logic        BI_n;
    logic        Frame;

    int pos = 0;
    int n_run = 0;
    int n_fail = 0;

    zjh_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
        .Clock     (Clock),
        .Aclr      (Aclr),
        .Din       (Din),
        .Din_valid (Din_valid),
        .Din_ready (Din_ready),
        .Lzb       (Lzb),
        .Sel       (Sel),
        .Bcd       (Bcd),
        .BI_n      (BI_n),
        .Frame     (Frame)
    );

    always #5 Clock = ~Clock;

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] s);
        return w[{s, 2'b00} +: 4];
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
        pos = (pos + 1) % 16;
    endtask

    task automatic step_to(input int p);
        for (int i = 0; i < 16 && pos != p; i++) tick();
    endtask

    task automatic offer(input logic [15:0] d);
        Din = d;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
    endtask

    task automatic test_reset();
        Aclr = 1'b1;
        Din_valid = 1'b1;
        Din = 16'hFFFF;
        tick();
        Aclr = 1'b0;
        Din_valid = 1'b0;
        pos = 0;
        n_run++;
        if ({Sel, Bcd, BI_n, Din_ready, Frame} !== {2'd0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got %b want %b", {Sel, Bcd, BI_n, Din_ready, Frame},
                     {2'd0, 4'h0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_idle();
        logic [1:0] es;
        for (int t = 1; t <= 16; t++) begin
            tick();
            es = 2'((t / 4) % 4);
            n_run++;
            if ({Sel, Bcd, BI_n, Frame} !== {es, 4'h0, (t % 4) != 0, t == 16}) begin
                n_fail++;
                $display("FAIL idle t=%0d got %b want %b", t, {Sel, Bcd, BI_n, Frame},
                         {es, 4'h0, (t % 4) != 0, t == 16});
            end
        end
    endtask

    task automatic test_load();
        logic [1:0] s;
        logic [3:0] eb;
        logic       ebi;
        step_to(6);
        n_run++;
        if (Din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_before got %b want 1", Din_ready);
        end
        offer(16'h1234);
        for (int p = 7; p < 16; p++) begin
            s = 2'(p / 4);
            n_run++;
            if ({Din_ready, Sel, Bcd} !== {1'b0, s, 4'h0}) begin
                n_fail++;
                $display("FAIL load_pending p=%0d got %b want %b", p, {Din_ready, Sel, Bcd},
                         {1'b0, s, 4'h0});
            end
            tick();
        end
        for (int p = 0; p < 16; p++) begin
            s = 2'(p / 4);
            eb = nib(16'h1234, s);
            ebi = (p % 4) != 0;
            n_run++;
            if ({Sel, Bcd, BI_n, Frame, Din_ready} !== {s, eb, ebi, p == 0, 1'b1}) begin
                n_fail++;
                $display("FAIL load_frame p=%0d got %b want %b", p,
                         {Sel, Bcd, BI_n, Frame, Din_ready}, {s, eb, ebi, p == 0, 1'b1});
            end
            tick();
        end
    endtask

    task automatic test_lzb();
        logic [15:0] words [3] = '{16'h0012, 16'h0000, 16'h0102};
        logic [3:0]  masks [3] = '{4'b0011, 4'b0001, 4'b0111};
        logic [1:0] s;
        logic [3:0] eb;
        logic       ebi;
        Lzb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_to(3);
            offer(words[k]);
            step_to(0);
            for (int p = 0; p < 16; p++) begin
                s = 2'(p / 4);
                eb = nib(words[k], s);
                ebi = ((p % 4) != 0) && masks[k][s];
                n_run++;
                if ({Sel, Bcd, BI_n} !== {s, eb, ebi}) begin
                    n_fail++;
                    $display("FAIL lzb w=%h p=%0d got %b want %b", words[k], p, {Sel, Bcd, BI_n},
                             {s, eb, ebi});
                end
                tick();
            end
        end
    endtask

    task automatic test_bad_digit();
        logic [15:0] words [2] = '{16'h1A34, 16'h00F0};
        logic [3:0]  masks [2] = '{4'b1011, 4'b0001};
        logic        lzbs  [2] = '{1'b0, 1'b1};
        logic [1:0] s;
        logic [3:0] eb;
        logic       ebi;
        for (int k = 0; k < 2; k++) begin
            Lzb = lzbs[k];
            step_to(3);
            offer(words[k]);
            step_to(0);
            for (int p = 0; p < 16; p++) begin
                s = 2'(p / 4);
                eb = nib(words[k], s);
                ebi = ((p % 4) != 0) && masks[k][s];
                n_run++;
                if ({Sel, Bcd, BI_n} !== {s, eb, ebi}) begin
                    n_fail++;
                    $display("FAIL bad_digit w=%h p=%0d got %b want %b", words[k], p,
                             {Sel, Bcd, BI_n}, {s, eb, ebi});
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3] = '{16'h00F0, 16'h5678, 16'h5678};
        logic [3:0]  masks [3] = '{4'b1101, 4'b1111, 4'b1111};
        logic        rdys  [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0] s;
        logic [3:0] eb;
        logic       ebi;
        Lzb = 1'b0;
        step_to(15);
        Din = 16'h5678;
        Din_valid = 1'b1;
        tick();
        // Second offer held high while the shadow is full must be ignored.
        Din = 16'h9999;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 16; p++) begin
                if (k == 0 && p == 10) Din_valid = 1'b0;
                s = 2'(p / 4);
                eb = nib(words[k], s);
                ebi = ((p % 4) != 0) && masks[k][s];
                n_run++;
                if ({Sel, Bcd, BI_n, Frame, Din_ready} !== {s, eb, ebi, p == 0, rdys[k]}) begin
                    n_fail++;
                    $display("FAIL back_to_back f=%0d p=%0d got %b want %b", k, p,
                             {Sel, Bcd, BI_n, Frame, Din_ready}, {s, eb, ebi, p == 0, rdys[k]});
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] s;
        int         pp;
        step_to(5);
        offer(16'h4321);
        step_to(9);
        n_run++;
        if (Din_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_full got %b want 0", Din_ready);
        end
        Aclr = 1'b1;
        Din = 16'h7777;
        Din_valid = 1'b1;
        tick();
        Aclr = 1'b0;
        Din_valid = 1'b0;
        pos = 0;
        n_run++;
        if ({Sel, Bcd, BI_n, Din_ready, Frame} !== {2'd0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_state got %b want %b", {Sel, Bcd, BI_n, Din_ready, Frame},
                     {2'd0, 4'h0, 1'b0, 1'b1, 1'b0});
        end
        for (int p = 1; p <= 32; p++) begin
            tick();
            pp = p % 16;
            s = 2'(pp / 4);
            n_run++;
            if ({Sel, Bcd, BI_n, Frame, Din_ready} !== {s, 4'h0, (pp % 4) != 0, pp == 0, 1'b1})
            begin
                n_fail++;
                $display("FAIL rst_mid_after p=%0d got %b want %b", p,
                         {Sel, Bcd, BI_n, Frame, Din_ready},
                         {s, 4'h0, (pp % 4) != 0, pp == 0, 1'b1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_lzb();
        test_bad_digit();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
